uart_tx_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter. It is the successor to the fixed 8N1 transmitter. It adds a valid/ready handshake with a one-entry holding register for gap-free back-to-back frames, a runtime baud divisor, selectable parity and one or two stop bits. It sits between a byte-stream producer (FIFO or CPU register) and the serial pad.

---
 rtl/uart_tx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// One-entry holding register behind a valid/ready handshake feeds a
// START/DATA/PARITY/STOP shifter. Divisor, parity mode and stop count are
// latched at frame start so mid-frame configuration changes are harmless.
module uart_tx_cfg #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

   // Parity bit for a data word: 01 odd, 10 even, 11 mark.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] d,
                                       input logic [1:0]           mode);
      case (mode)
         2'b01:   return ~(^d);
         2'b10:   return ^d;
         default: return 1'b1;
      endcase
   endfunction

   // Divisors below 2 cannot give a full bit period; clamp to 2.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d < DIV_W'(2)) ? DIV_W'(2) : d;
   endfunction

   state_t               state;
   logic                 hold_full;
   logic [DATA_BITS-1:0] hold_data;
   logic [DATA_BITS-1:0] shreg;
   logic [DIV_W-1:0]     cnt;
   logic [DIV_W-1:0]     div_lat;
   logic [3:0]           bit_cnt;
   logic                 par_en;
   logic                 par_val;
   logic                 stop2_lat;

   logic accept;
   logic tick;
   logic stop_end;
   logic load;
   logic hold_next;
   logic go_idle;

   assign tx_ready  = ~hold_full;
   assign accept    = tx_valid & ~hold_full;
   assign tick      = (cnt == div_lat - DIV_W'(1));
   assign stop_end  = (state == STOP) && tick && (!stop2_lat || bit_cnt == 4'd1);
   // A full holding register starts a frame from IDLE or straight off the last stop bit.
   assign load      = hold_full && ((state == IDLE) || stop_end);
   assign hold_next = accept | (hold_full & ~load);
   assign go_idle   = ((state == IDLE) || stop_end) && !hold_full;

   // Holding register occupancy flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) hold_full <= 1'b0;
      else          hold_full <= hold_next;
   end

   // Holding register payload and the shifter/parity it feeds (data path, no reset).
   always_ff @(posedge clk) begin
      if (accept) hold_data <= tx_data;
      if (load) begin
         shreg   <= hold_data;
         par_val <= parity_bit(hold_data, parity_mode);
      end else if (state == DATA && tick) begin
         shreg <= shreg >> 1;
      end
   end

   // Frame FSM with registered tx, busy and frame_done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         div_lat    <= DIV_W'(2);
         par_en     <= 1'b0;
         stop2_lat  <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= stop_end;
         busy       <= ~go_idle | hold_next;
         if (load) begin
            state     <= START;
            cnt       <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b0;
            div_lat   <= eff_div(baud_div);
            par_en    <= |parity_mode;
            stop2_lat <= stop2;
         end else begin
            case (state)
               IDLE: begin
                  tx <= 1'b1;
               end
               START: begin
                  if (tick) begin
                     cnt     <= '0;
                     bit_cnt <= '0;
                     state   <= DATA;
                     tx      <= shreg[0];
                  end else begin
                     cnt <= cnt + DIV_W'(1);
                  end
               end
               DATA: begin
                  if (tick) begin
                     cnt <= '0;
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en) begin
                           state <= PARITY;
                           tx    <= par_val;
                        end else begin
                           state <= STOP;
                           tx    <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx      <= shreg[1];
                     end
                  end else begin
                     cnt <= cnt + DIV_W'(1);
                  end
               end
               PARITY: begin
                  if (tick) begin
                     cnt     <= '0;
                     bit_cnt <= '0;
                     state   <= STOP;
                     tx      <= 1'b1;
                  end else begin
                     cnt <= cnt + DIV_W'(1);
                  end
               end
               STOP: begin
                  if (tick) begin
                     cnt <= '0;
                     if (stop_end) begin
                        bit_cnt <= '0;
                        state   <= IDLE;
                        tx      <= 1'b1;
                     end else begin
                        bit_cnt <= 4'd1;
                     end
                  end else begin
                     cnt <= cnt + DIV_W'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: directed frames, scoreboard queue of expected
// frames, and a line monitor that checks every cycle of each bit period.
module tb_uart_tx_cfg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        stop2;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready, tx, busy, frame_done;
   logic [4:0]  tx_data5;
   logic        tx_valid5;
   logic        tx_ready5, tx5, busy5, frame_done5;

   always #5 clk = ~clk;

   uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .stop2(stop2), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx(tx), .busy(busy), .frame_done(frame_done));

   uart_tx_cfg #(.DATA_BITS(5), .DIV_W(16)) dut5 (
      .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .stop2(stop2), .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready5),
      .tx(tx5), .busy(busy5), .frame_done(frame_done5));

   typedef struct {
      logic [8:0] data;
      int         div;
      int         nbits;
      int         par;    // -1 none, else expected parity bit
      int         nstop;
      bit         b2b;    // must start with no idle cycle after the previous frame
   } frame_t;

   frame_t q[$];
   int     checks = 0;
   int     errors = 0;
   bit     sel5 = 1'b0;
   bit     mon_en = 1'b1;
   bit     mon_active = 1'b0;
   logic   mon_tx, mon_fd;

   assign mon_tx = sel5 ? tx5 : tx;
   assign mon_fd = sel5 ? frame_done5 : frame_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic frame_t mk(input logic [8:0] d, input int div, input int nbits,
                                 input int par, input int nstop, input bit b2b);
      frame_t f;
      f.data = d; f.div = div; f.nbits = nbits; f.par = par; f.nstop = nstop; f.b2b = b2b;
      return f;
   endfunction

   // Line monitor: pops one expected frame per start bit and checks it cycle by cycle.
   initial begin : monitor
      frame_t e;
      logic   exp_bits [0:15];
      bit     chained;
      bit     found;
      bit     was_chained;
      int     n;
      int     bad;
      chained = 1'b0;
      forever begin
         if (q.size() == 0) begin
            if (chained) begin
               check("unexpected_start", 1, 0);
               chained = 1'b0;
            end
            @(negedge clk);
            if (mon_en && q.size() == 0 && mon_tx !== 1'b1) check("idle_line", mon_tx, 1);
         end else begin
            e = q.pop_front();
            mon_active = 1'b1;
            n = 0;
            exp_bits[n] = 1'b0; n++;
            for (int i = 0; i < e.nbits; i++) begin exp_bits[n] = e.data[i]; n++; end
            if (e.par >= 0) begin exp_bits[n] = (e.par == 1); n++; end
            for (int i = 0; i < e.nstop; i++) begin exp_bits[n] = 1'b1; n++; end
            if (e.b2b) check($sformatf("no_idle_gap_%0h", e.data), chained, 1);
            was_chained = chained;
            found = chained;
            if (!found) begin
               for (int w = 0; w < 60; w++) begin
                  @(negedge clk);
                  if (mon_tx === 1'b0) begin found = 1'b1; break; end
               end
            end
            if (!found) begin
               check($sformatf("start_timeout_%0h", e.data), 0, 1);
               chained = 1'b0;
            end else begin
               for (int b = 0; b < n; b++) begin
                  bad = 0;
                  for (int c = 0; c < e.div; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (mon_tx !== exp_bits[b]) bad++;
                     if (mon_fd !== 1'b0 && !(b == 0 && c == 0 && was_chained)) bad++;
                  end
                  check($sformatf("frame_%0h_bit%0d_bad_cycles", e.data, b), bad, 0);
               end
               @(negedge clk);
               check($sformatf("frame_done_%0h", e.data), mon_fd, 1);
               chained = (mon_tx === 1'b0);
            end
            mon_active = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] d, input bit push, input frame_t f);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = d;
      for (int w = 0; w < 200; w++) begin
         if (tx_ready === 1'b1) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) check("ready_timeout", 0, 1);
      if (push) q.push_back(f);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int w = 0; w < 2000; w++) begin
         @(negedge clk);
         if (q.size() == 0 && !mon_active) break;
      end
      check("drain", q.size() + int'(mon_active), 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int bad;
      reset_n = 1'b0; baud_div = 16'd4; parity_mode = 2'b00; stop2 = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; tx_data5 = 5'h00; tx_valid5 = 1'b0;
      #12;
      check("rst_tx", tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_tx5", tx5, 1);
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Test 1: 0x55, div 4, 8N1, with latency and handshake checks.
      @(negedge clk);
      check("t1_ready_before", tx_ready, 1);
      tx_valid = 1'b1; tx_data = 8'h55;
      q.push_back(mk(9'h055, 4, 8, -1, 1, 1'b0));
      @(posedge clk); #1;
      tx_valid = 1'b0;
      check("t1_ready_after_accept", tx_ready, 0);
      check("t1_busy_after_accept", busy, 1);
      check("t1_tx_still_idle", tx, 1);
      @(posedge clk); #1;
      check("t1_tx_start", tx, 0);
      check("t1_ready_after_load", tx_ready, 1);
      wait_idle();
      check("t1_busy_end", busy, 0);
      check("t1_tx_end", tx, 1);

      // Test 2: parity modes, 44-clock frames.
      parity_mode = 2'b10; send(8'h07, 1'b1, mk(9'h007, 4, 8, 1, 1, 1'b0)); wait_idle();
      parity_mode = 2'b01; send(8'h07, 1'b1, mk(9'h007, 4, 8, 0, 1, 1'b0)); wait_idle();
      parity_mode = 2'b11; send(8'h00, 1'b1, mk(9'h000, 4, 8, 1, 1, 1'b0)); wait_idle();
      parity_mode = 2'b00;

      // Test 3: back-to-back 0xA5, 0x3C, div 3, two stop bits.
      baud_div = 16'd3; stop2 = 1'b1;
      @(negedge clk);
      tx_valid = 1'b1; tx_data = 8'hA5;
      q.push_back(mk(9'h0A5, 3, 8, -1, 2, 1'b0));
      @(negedge clk);
      check("t3_ready_low_1", tx_ready, 0);
      tx_data = 8'h3C;
      @(negedge clk);
      check("t3_ready_high_gap", tx_ready, 1);
      check("t3_first_start", tx, 0);
      q.push_back(mk(9'h03C, 3, 8, -1, 2, 1'b1));
      @(negedge clk);
      check("t3_ready_low_2", tx_ready, 0);
      tx_valid = 1'b0;
      wait_idle();
      check("t3_busy_end", busy, 0);
      stop2 = 1'b0;

      // Test 4: divisor clamp and mid-frame divisor change.
      baud_div = 16'd0; send(8'h96, 1'b1, mk(9'h096, 2, 8, -1, 1, 1'b0)); wait_idle();
      baud_div = 16'd1; send(8'h69, 1'b1, mk(9'h069, 2, 8, -1, 1, 1'b0)); wait_idle();
      baud_div = 16'd4; send(8'hC3, 1'b1, mk(9'h0C3, 4, 8, -1, 1, 1'b0));
      repeat (10) @(negedge clk);
      baud_div = 16'd8;
      wait_idle();
      send(8'h3C, 1'b1, mk(9'h03C, 8, 8, -1, 1, 1'b0)); wait_idle();

      // Test 5: asynchronous reset mid-DATA with a byte held.
      mon_en = 1'b0; baud_div = 16'd4;
      send(8'h00, 1'b0, mk(9'h000, 4, 8, -1, 1, 1'b0));
      send(8'hFF, 1'b0, mk(9'h0FF, 4, 8, -1, 1, 1'b0));
      repeat (10) @(negedge clk);
      check("t5_tx_low_in_data", tx, 0);
      check("t5_byte_held", tx_ready, 0);
      #2 reset_n = 1'b0;
      #1;
      check("t5_rst_tx", tx, 1);
      check("t5_rst_ready", tx_ready, 1);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_frame_done", frame_done, 0);
      @(negedge clk); reset_n = 1'b1;
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) bad++;
      end
      check("t5_quiet_after_reset", bad, 0);
      mon_en = 1'b1;
      send(8'h81, 1'b1, mk(9'h081, 4, 8, -1, 1, 1'b0)); wait_idle();

      // Test 6: 5-bit build, 0x1F even parity, 8 bit periods.
      sel5 = 1'b1; parity_mode = 2'b10; baud_div = 16'd4;
      @(negedge clk);
      check("t6_ready5", tx_ready5, 1);
      tx_valid5 = 1'b1; tx_data5 = 5'h1F;
      q.push_back(mk(9'h01F, 4, 5, 1, 1, 1'b0));
      @(negedge clk);
      tx_valid5 = 1'b0;
      wait_idle();
      check("t6_busy5_end", busy5, 0);
      sel5 = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
